pipe_ctrl: RTL

Sequencing controller for the 3-stage (IF/ID/EX) processor pipeline. It drives the enable and flush inputs of the PC register and of the IF/ID and ID/EX pipeline register banks (banks of enable-gated dff cells). It tracks per-stage valid bits and handles stalls, bubbles, branch flushes, halt and instruction-memory timeout.

---
 rtl/pipe_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Sequencing controller for a 3-stage IF/ID/EX pipeline.
// Drives the PC and pipeline-bank enables and flushes, and tracks per-stage valid bits.
module pipe_ctrl #(
  parameter int STALL_CW    = 8,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                start,
  input  logic                mem_wait,
  input  logic                hazard,
  input  logic                branch_taken,
  input  logic                halt_req,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                id_ex_en,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                v_id,
  output logic                v_ex,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [STALL_CW-1:0] stall_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       run;
  logic       do_halt;
  logic       do_branch;
  logic       do_bubble;
  logic       do_wait;
  logic       do_adv;
  logic       timeout;

  // One-hot rule selection; earlier rules mask later ones.
  always_comb begin
    run       = (state == S_RUN);
    do_halt   = run & halt_req & v_ex;
    do_branch = run & ~do_halt & branch_taken & v_ex;
    do_bubble = run & ~do_halt & ~do_branch & hazard & v_id;
    do_wait   = run & ~do_halt & ~do_branch & ~do_bubble & mem_wait;
    do_adv    = run & ~do_halt & ~do_branch & ~do_bubble & ~mem_wait;
    timeout   = do_wait & (wait_cnt == WAIT_LAST);

    pc_en       = do_branch | do_adv;
    if_id_en    = do_branch | do_wait | do_adv;
    id_ex_en    = do_branch | do_bubble | do_wait | do_adv;
    if_id_flush = do_halt | do_branch | do_wait;
    id_ex_flush = do_halt | do_branch | do_bubble;

    busy   = run;
    halted = (state == S_HALTED);
    err    = (state == S_ERROR);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_IDLE;
      v_id      <= 1'b0;
      v_ex      <= 1'b0;
      stall_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state     <= S_RUN;
            v_id      <= 1'b0;
            v_ex      <= 1'b0;
            stall_cnt <= '0;
            wait_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
          if (do_wait) wait_cnt <= wait_cnt + 8'd1;
          else         wait_cnt <= '0;

          if (do_halt) begin
            state <= S_HALTED;
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
          end else if (do_branch) begin
            v_id <= 1'b0;
            v_ex <= 1'b0;
          end else if (do_bubble) begin
            v_ex <= 1'b0;
          end else if (do_wait) begin
            // The timeout edge drops everything in flight instead of advancing it.
            if (timeout) begin
              state <= S_ERROR;
              v_id  <= 1'b0;
              v_ex  <= 1'b0;
            end else begin
              v_ex <= v_id;
              v_id <= 1'b0;
            end
          end else begin
            v_ex <= v_id;
            v_id <= 1'b1;
          end
        end
        default: begin
          state <= S_ERROR;
        end
      endcase
    end
  end

endmodule
